// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline controller: stall bus encodings and controller states.
package pipe_ctrl_pkg;

    localparam logic RST_ENABLE = 1'b1;

    typedef logic [31:0] inst_addr_t;
    typedef logic [5:0]  stall_t;

    // bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
    localparam stall_t STALL_NONE = 6'b000000;
    localparam stall_t STALL_ID   = 6'b000111;
    localparam stall_t STALL_EX   = 6'b001111;
    localparam stall_t STALL_MEM  = 6'b011111;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_BUSY = 2'd1,
        FLUSH   = 2'd2
    } ctrl_state_t;

    // Deepest requesting stage wins: MEM > EX > ID.
    function automatic stall_t stall_merge(input logic req_mem, input logic req_ex,
                                           input logic req_id);
        stall_t s;
        if (req_mem)
            s = STALL_MEM;
        else if (req_ex)
            s = STALL_EX;
        else if (req_id)
            s = STALL_ID;
        else
            s = STALL_NONE;
        return s;
    endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: merges stage stall requests, sequences
// multi-cycle EX ops with a down-counter and issues exception flushes.
//
// state   | meaning
// --------+--------------------------------------------------------
// RUN     | normal operation, stage stall requests merged
// MC_BUSY | multi-cycle EX op counting down, EX held until cnt==0
// FLUSH   | single flush cycle, new_pc carries the latched vector
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MC_CNT_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stallreq_id,
    input  logic                stallreq_ex,
    input  logic                stallreq_mem,
    input  logic                ex_mc_req,
    input  logic [MC_CNT_W-1:0] ex_mc_len,
    input  logic                excp_req,
    input  inst_addr_t          excp_vec,
    output stall_t              stall,
    output logic                flush,
    output inst_addr_t          new_pc,
    output logic                ex_mc_done,
    output logic                busy
);

    localparam logic [MC_CNT_W-1:0] CNT_ONE = MC_CNT_W'(1);
    localparam logic [MC_CNT_W-1:0] CNT_TWO = MC_CNT_W'(2);

    ctrl_state_t         state_q, state_d;
    logic [MC_CNT_W-1:0] cnt_q, cnt_d;
    inst_addr_t          vec_q, vec_d;

    logic mc_stall;
    logic mc_done;

    // Next-state, counter and vector latch plus the combinational outputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        vec_d    = vec_q;
        mc_stall = 1'b0;
        mc_done  = 1'b0;

        unique case (state_q)
            RUN: begin
                if (excp_req) begin
                    // Exception beats any op start; the op never enters the counter.
                    vec_d   = excp_vec;
                    state_d = FLUSH;
                end else if (ex_mc_req) begin
                    if (ex_mc_len >= CNT_TWO) begin
                        mc_stall = 1'b1;
                        cnt_d    = ex_mc_len - CNT_TWO;
                        state_d  = MC_BUSY;
                    end else begin
                        // Length 0 or 1 completes in its own request cycle.
                        mc_done = 1'b1;
                    end
                end
            end
            MC_BUSY: begin
                if (excp_req) begin
                    // Aborted op releases EX immediately and never reports done.
                    cnt_d   = '0;
                    vec_d   = excp_vec;
                    state_d = FLUSH;
                end else if (cnt_q != '0) begin
                    // Counting continues under a MEM stall; EX holds its result
                    // until stall[3] drops.
                    mc_stall = 1'b1;
                    cnt_d    = cnt_q - CNT_ONE;
                end else begin
                    mc_done = 1'b1;
                    state_d = RUN;
                end
            end
            FLUSH: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase

        if (rst == RST_ENABLE || state_q == FLUSH)
            stall = STALL_NONE;
        else
            stall = stall_merge(stallreq_mem, stallreq_ex || mc_stall, stallreq_id);

        flush      = (rst != RST_ENABLE) && (state_q == FLUSH);
        new_pc     = flush ? vec_q : '0;
        ex_mc_done = (rst != RST_ENABLE) && mc_done;
        busy       = (rst != RST_ENABLE) && (state_q == MC_BUSY);
    end

    // State, counter and exception vector registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q <= RUN;
            cnt_q   <= '0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_pipe_ctrl;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         stallreq_id = 1'b0;
    logic         stallreq_ex = 1'b0;
    logic         stallreq_mem = 1'b0;
    logic         ex_mc_req = 1'b0;
    logic [W-1:0] ex_mc_len = '0;
    logic         excp_req = 1'b0;
    logic [31:0]  excp_vec = '0;
    logic [5:0]   stall;
    logic         flush;
    logic [31:0]  new_pc;
    logic         ex_mc_done;
    logic         busy;

    int total = 0;
    int bad = 0;

    pipe_ctrl #(.MC_CNT_W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .stallreq_id (stallreq_id),
        .stallreq_ex (stallreq_ex),
        .stallreq_mem(stallreq_mem),
        .ex_mc_req   (ex_mc_req),
        .ex_mc_len   (ex_mc_len),
        .excp_req    (excp_req),
        .excp_vec    (excp_vec),
        .stall       (stall),
        .flush       (flush),
        .new_pc      (new_pc),
        .ex_mc_done  (ex_mc_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // mode: 0 normal, 1 op in progress, 2 flushing.
    // An op of length L started at cycle 0 is done at cycle L-1; op_age counts
    // cycles since the start.
    int          m_mode = 0;
    int          m_age = 0;
    int          m_len = 0;
    logic [31:0] m_vec = '0;

    always @(negedge clk) begin
        logic [5:0]  e_stall;
        logic        e_flush, e_done, e_busy, internal, skip_stall;
        logic [31:0] e_pc;
        internal   = 1'b0;
        e_done     = 1'b0;
        e_flush    = 1'b0;
        e_pc       = 32'h0;
        e_busy     = 1'b0;
        skip_stall = 1'b0;
        if (rst) begin
            e_stall = 6'b000000;
            m_mode  = 0;
            m_vec   = 32'h0;
        end else begin
            if (m_mode == 2) begin
                e_flush = 1'b1;
                e_pc    = m_vec;
                m_mode  = 0;
            end else if (m_mode == 0) begin
                if (excp_req) begin
                    skip_stall = ex_mc_req && (int'(ex_mc_len) >= 2);
                    m_vec  = excp_vec;
                    m_mode = 2;
                end else if (ex_mc_req) begin
                    if (int'(ex_mc_len) >= 2) begin
                        internal = 1'b1;
                        m_len    = int'(ex_mc_len);
                        m_age    = 1;
                        m_mode   = 1;
                    end else begin
                        e_done = 1'b1;
                    end
                end
            end else begin
                e_busy = 1'b1;
                if (excp_req) begin
                    skip_stall = 1'b1;
                    m_vec  = excp_vec;
                    m_mode = 2;
                end else if (m_age == m_len - 1) begin
                    e_done = 1'b1;
                    m_mode = 0;
                end else begin
                    internal = 1'b1;
                    m_age    = m_age + 1;
                end
            end
            if (e_flush)                       e_stall = 6'b000000;
            else if (stallreq_mem)             e_stall = 6'b011111;
            else if (stallreq_ex || internal)  e_stall = 6'b001111;
            else if (stallreq_id)              e_stall = 6'b000111;
            else                               e_stall = 6'b000000;
        end
        if (!skip_stall) begin
            total++;
            if (stall !== e_stall) begin
                bad++;
                $display("FAIL model_stall t=%0t got=%b want=%b", $time, stall, e_stall);
            end
        end
        total++;
        if (flush !== e_flush || new_pc !== e_pc) begin
            bad++;
            $display("FAIL model_flush t=%0t got=%b/%h want=%b/%h", $time, flush, new_pc, e_flush, e_pc);
        end
        total++;
        if (ex_mc_done !== e_done || busy !== e_busy) begin
            bad++;
            $display("FAIL model_done_busy t=%0t got=%b/%b want=%b/%b", $time, ex_mc_done, busy, e_done, e_busy);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic put(input logic id, input logic ex, input logic mem, input logic mcr,
                       input int len, input logic ex_req, input logic [31:0] vec);
        stallreq_id  = id;
        stallreq_ex  = ex;
        stallreq_mem = mem;
        ex_mc_req    = mcr;
        ex_mc_len    = W'(len);
        excp_req     = ex_req;
        excp_vec     = vec;
    endtask

    task automatic idle();
        put(0, 0, 0, 0, 0, 0, 32'h0);
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        look(); chk("reset_stall", 32'(stall), 32'h0);
        chk("reset_flush_pc", {31'h0, flush} | new_pc, 32'h0);
        chk("reset_busy_done", {30'h0, busy, ex_mc_done}, 32'h0);
        tick();
        rst = 1'b0;

        for (int i = 0; i < 3; i++) begin
            look(); chk("idle_stall", 32'(stall), 32'h0);
            tick();
        end

        put(1, 0, 0, 0, 0, 0, 32'h0); look(); chk("id_stall", 32'(stall), 32'h07); tick();
        idle();                       look(); chk("id_release", 32'(stall), 32'h00); tick();
        put(1, 1, 0, 0, 0, 0, 32'h0); look(); chk("id_ex_stall", 32'(stall), 32'h0f); tick();
        put(1, 1, 1, 0, 0, 0, 32'h0); look(); chk("mem_stall", 32'(stall), 32'h1f); tick();

        // length-4 op held in EX
        for (int c = 0; c < 4; c++) begin
            put(0, 0, 0, 1, 4, 0, 32'h0);
            look();
            chk("mc4_stall", 32'(stall), (c < 3) ? 32'h0f : 32'h00);
            chk("mc4_done", 32'(ex_mc_done), (c == 3) ? 32'h1 : 32'h0);
            chk("mc4_busy", 32'(busy), (c >= 1) ? 32'h1 : 32'h0);
            tick();
        end
        idle(); look(); chk("mc4_after_busy", 32'(busy), 32'h0); tick();

        // degenerate lengths finish in the request cycle
        for (int l = 1; l >= 0; l--) begin
            put(0, 0, 0, 1, l, 0, 32'h0);
            look();
            chk("mc_short_stall", 32'(stall), 32'h0);
            chk("mc_short_done", 32'(ex_mc_done), 32'h1);
            tick();
            idle(); look(); chk("mc_short_busy", 32'(busy), 32'h0); tick();
        end

        // exception aborts a length-10 op in cycle 3
        for (int c = 0; c < 3; c++) begin
            put(0, 0, 0, 1, 10, 0, 32'h0); look();
            chk("abort_pre_done", 32'(ex_mc_done), 32'h0);
            tick();
        end
        put(0, 0, 0, 1, 10, 1, 32'h20); look(); chk("abort_cyc_done", 32'(ex_mc_done), 32'h0); tick();
        put(0, 0, 0, 1, 10, 1, 32'h44); look();
        chk("flush_flag", 32'(flush), 32'h1);
        chk("flush_pc", new_pc, 32'h20);
        chk("flush_stall", 32'(stall), 32'h0);
        tick();
        idle(); look();
        chk("post_flush", {30'h0, flush, busy}, 32'h0);
        chk("post_flush_pc", new_pc, 32'h0);
        tick();

        // reset mid-op, then a fresh length-3 op
        for (int c = 0; c < 5; c++) begin
            put(0, 0, 0, 1, 20, 0, 32'h0); tick();
        end
        rst = 1'b1; look(); chk("mid_rst_busy", 32'(busy), 32'h0); tick();
        rst = 1'b0; idle(); look();
        chk("after_rst_stall", 32'(stall), 32'h0);
        chk("after_rst_busy", 32'(busy), 32'h0);
        tick();
        for (int c = 0; c < 3; c++) begin
            put(0, 0, 0, 1, 3, 0, 32'h0); look();
            chk("mc3_stall", 32'(stall), (c < 2) ? 32'h0f : 32'h00);
            chk("mc3_done", 32'(ex_mc_done), (c == 2) ? 32'h1 : 32'h0);
            tick();
        end

        // randomized traffic checked by the model
        for (int n = 0; n < 3000; n++) begin
            rst          = ($urandom_range(0, 99) < 1);
            stallreq_id  = ($urandom_range(0, 99) < 20);
            stallreq_ex  = ($urandom_range(0, 99) < 10);
            stallreq_mem = ($urandom_range(0, 99) < 15);
            excp_req     = ($urandom_range(0, 99) < 3);
            excp_vec     = $urandom;
            ex_mc_req    = ($urandom_range(0, 99) < 25);
            ex_mc_len    = W'($urandom_range(0, 12));
            if ($urandom_range(0, 99) < 3) ex_mc_len = W'(63);
            tick();
        end

        rst = 1'b0;
        idle();
        for (int i = 0; i < 70; i++) tick();
        look();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline controller for the 5-stage MIPS core; sole driver of the stall[5:0] bus into pc_reg, if_id, id_ex, ex_mem and mem_wb.
- Merges stall requests from ID, EX and MEM.
- Sequences multi-cycle EX operations (div, madd/msub) with an internal down-counter, then releases the pipeline.
- On an exception request, issues a one-cycle flush with a redirect PC.

Parameters:
- MC_CNT_W, 6, width of multi-cycle length and counter (max op length 63 cycles).

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous, active-high reset; asserted value RST_ENABLE.
- stallreq_id  in  1  load-use hazard from ID.
- stallreq_ex  in  1  single-cycle EX hold request, combinational.
- stallreq_mem  in  1  data-memory wait.
- ex_mc_req  in  1  EX holds a multi-cycle op; stays high while that op is held in EX.
- ex_mc_len  in  MC_CNT_W  total EX occupancy in cycles, including the request cycle.
- excp_req  in  1  exception detected in MEM.
- excp_vec  in  32 (inst_addr_t)  handler address.
- stall  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
- flush  out  1  clear all pipeline registers.
- new_pc  out  32 (inst_addr_t)  redirect target, valid while flush=1.
- ex_mc_done  out  1  one-cycle pulse in the final cycle of a multi-cycle op.
- busy  out  1  high while state is MC_BUSY.

Behaviour:
- Reset values (rst=1 at posedge):
  - state=RUN, cnt=0, latched vector=0.
  - Outputs while reset is asserted: stall=0, flush=0, new_pc=0, ex_mc_done=0, busy=0.
  - Reset overrides everything, including a reset in MC_BUSY or FLUSH: the next cycle is clean RUN.
- States:
  - RUN: normal operation.
  - MC_BUSY: a multi-cycle op is counting down in EX.
  - FLUSH: one cycle of pipeline flush.
- stall is combinational from state and inputs, with zero latency. Encodings:
  - STALL_NONE = 000000
  - STALL_ID = 000111
  - STALL_EX = 001111
  - STALL_MEM = 011111
- Stall priority: FLUSH state gives 000000. Otherwise the deepest requesting stage wins, in the order MEM > EX (external or internal multi-cycle) > ID.
- This encoding makes id_ex insert a bubble under STALL_ID and hold its contents under STALL_EX/STALL_MEM.
- RUN transitions:
  - excp_req=1: latch excp_vec; next state FLUSH. This takes priority over every other event.
  - Otherwise, ex_mc_req=1 with ex_mc_len>=2: assert STALL_EX this cycle, load cnt<=ex_mc_len-2, next state MC_BUSY.
  - ex_mc_req=1 with ex_mc_len of 0 or 1: treated as a single-cycle op. No internal stall; ex_mc_done=1 in the same cycle.
- MC_BUSY:
  - ex_mc_req is ignored, because the same instruction is held in EX.
  - cnt!=0: assert STALL_EX, cnt<=cnt-1.
  - cnt==0: internal stall released, ex_mc_done=1, next state RUN.
  - Total internal stall cycles = ex_mc_len-1, and done is pulsed in cycle ex_mc_len-1, counting the request cycle as cycle 0.
  - stallreq_mem during MC_BUSY raises stall to STALL_MEM but does not pause the counter.
  - If cnt reaches 0 while stallreq_mem is high, ex_mc_done still pulses and the state returns to RUN. EX logic must hold its result until stall[3]=0.
  - excp_req=1: abort the op, cnt<=0, no ex_mc_done, latch excp_vec, next state FLUSH.
- FLUSH:
  - flush=1, new_pc=latched vector, stall=000000.
  - Lasts exactly 1 cycle; next state RUN.
  - excp_req during FLUSH is ignored.
  - new_pc is 0 whenever flush=0.
- Counter arithmetic: unsigned MC_CNT_W-bit, no wrap. Decrement occurs only when cnt!=0.

Decomposition:
- project_types gains:
  - stall_t (logic [5:0]);
  - the STALL_NONE/ID/EX/MEM localparams;
  - the ctrl_state_t enum {RUN, MC_BUSY, FLUSH}.
- A single module with one always_ff block for state/cnt/vector and one always_comb block for outputs.
- No sub-module is needed.

Test Plan:
- Reset for 2 cycles, then idle inputs -> stall=000000, flush=0, new_pc=0, busy=0 every cycle.
- stallreq_id=1 for 1 cycle -> stall=000111 in that cycle only; stallreq_id and stallreq_ex together -> 001111; stallreq_mem added -> 011111.
- ex_mc_req=1 held, ex_mc_len=4 -> stall=001111 for cycles 0-2, stall=000000 with ex_mc_done=1 in cycle 3, busy=1 in cycles 1-3.
- ex_mc_len=1 and ex_mc_len=0 -> no stall, ex_mc_done=1 in the request cycle, state stays RUN.
- ex_mc_len=10, excp_req=1 with excp_vec=0x0000_0020 in cycle 3 -> next cycle flush=1, new_pc=0x20, stall=0; following cycle RUN; ex_mc_done never pulses.
- rst=1 mid-MC_BUSY (ex_mc_len=20, cycle 5) -> stall=0, busy=0 in the cycle after reset; a fresh ex_mc_len=3 then yields 2 stall cycles.
